// File: rtl/l1c_cbus_mst.sv
// Cache-bus initiator: issues L1 read/write requests with unique UIDs and routes read returns back by tag.
// Optional ack-wait watchdog enabled by defining CBUS_MST_TIMEOUT_EN.
module l1c_cbus_mst #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int UID_W   = 3,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst_,
    input  logic                  req_valid,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [TAG_W-1:0]      req_tag,
    input  logic [DATA_W/8-1:0]   req_be,
    input  logic [DATA_W-1:0]     req_data,
    output logic                  req_ready,
    output logic                  cbus_m_req,
    output logic [1:0]            cbus_m_cmd,
    output logic [ADDR_W-1:0]     cbus_m_addr,
    output logic [UID_W-1:0]      cbus_m_uid,
    output logic [DATA_W/8-1:0]   cbus_m_data_be,
    output logic [DATA_W-1:0]     cbus_m_data,
    input  logic                  cbus_m_ack,
    input  logic                  cbus_s_rdy,
    input  logic [UID_W-1:0]      cbus_s_uid,
    input  logic [DATA_W-1:0]     cbus_s_data,
    output logic                  rsp_valid,
    output logic [TAG_W-1:0]      rsp_tag,
    output logic [DATA_W-1:0]     rsp_data,
    output logic                  err
);
    localparam int NUID = 1 << UID_W;
    localparam int BE_W = DATA_W / 8;
    localparam logic [1:0] CMD_RD = 2'b00;
    localparam logic [1:0] CMD_WR = 2'b01;

    typedef enum logic {S_IDLE, S_ISSUE} state_t;

    state_t                r_state, w_state_nxt;
    logic [NUID-1:0]       r_busy, w_busy_nxt;
    logic [TAG_W-1:0]      r_tag [NUID];
    logic [1:0]            r_cmd;
    logic [ADDR_W-1:0]     r_addr;
    logic [UID_W-1:0]      r_uid;
    logic [BE_W-1:0]       r_be;
    logic [DATA_W-1:0]     r_data;
    logic                  r_rsp_valid;
    logic [TAG_W-1:0]      r_rsp_tag;
    logic [DATA_W-1:0]     r_rsp_data;
    logic                  r_err;

    logic                  w_have_free;
    logic [UID_W-1:0]      w_alloc_uid;
    logic                  w_accept, w_ack, w_ret_ok, w_ret_bad, w_to_hit;

    // Lowest clear bit of the pre-free bitmap, so frees this cycle never collide with the allocation.
    always_comb begin
        w_have_free = 1'b0;
        w_alloc_uid = '0;
        for (int i = NUID - 1; i >= 0; i--) begin
            if (!r_busy[i]) begin
                w_have_free = 1'b1;
                w_alloc_uid = UID_W'(i);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        cbus_m_req  = 1'b0;
        req_ready   = 1'b0;
        w_accept    = 1'b0;
        w_ack       = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = w_have_free;
                w_accept  = req_valid && w_have_free;
                if (w_accept) w_state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                cbus_m_req = 1'b1;
                w_ack      = cbus_m_ack;
                req_ready  = cbus_m_ack && w_have_free;
                w_accept   = req_valid && req_ready;
                if (w_ack && !w_accept) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // A return is only legal for a busy UID that has already left the issue register.
    assign w_ret_ok  = cbus_s_rdy && r_busy[cbus_s_uid]
                       && !((r_state == S_ISSUE) && (r_uid == cbus_s_uid));
    assign w_ret_bad = cbus_s_rdy && !w_ret_ok;

    always_comb begin
        w_busy_nxt = r_busy;
        if (w_ack && (r_cmd == CMD_WR)) w_busy_nxt[r_uid] = 1'b0;
        if (w_ret_ok) w_busy_nxt[cbus_s_uid] = 1'b0;
        if (w_accept) w_busy_nxt[w_alloc_uid] = 1'b1;
    end

`ifdef CBUS_MST_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] r_to_cnt;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_to_cnt <= '0;
        end else if ((r_state != S_ISSUE) || cbus_m_ack) begin
            r_to_cnt <= '0;
        end else if (r_to_cnt != TO_W'(TIMEOUT)) begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
        end
    end

    assign w_to_hit = (r_state == S_ISSUE) && !cbus_m_ack && (r_to_cnt == TO_W'(TIMEOUT - 1));
`else
    // No watchdog; the comparison is constant false and only keeps TIMEOUT referenced.
    assign w_to_hit = (TIMEOUT < 0);
`endif

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_state <= S_IDLE;
            r_busy  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) r_tag[w_alloc_uid] <= req_tag;
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_cmd  <= '0;
            r_addr <= '0;
            r_uid  <= '0;
            r_be   <= '0;
            r_data <= '0;
        end else if (w_accept) begin
            r_cmd  <= req_we ? CMD_WR : CMD_RD;
            r_addr <= req_addr;
            r_uid  <= w_alloc_uid;
            r_be   <= req_we ? req_be : {BE_W{1'b1}};
            r_data <= req_we ? req_data : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_rsp_valid <= 1'b0;
            r_rsp_tag   <= '0;
            r_rsp_data  <= '0;
            r_err       <= 1'b0;
        end else begin
            r_rsp_valid <= w_ret_ok;
            if (w_ret_ok) begin
                r_rsp_tag  <= r_tag[cbus_s_uid];
                r_rsp_data <= cbus_s_data;
            end
            if (w_ret_bad || w_to_hit) r_err <= 1'b1;
        end
    end

    assign cbus_m_cmd     = r_cmd;
    assign cbus_m_addr    = r_addr;
    assign cbus_m_uid     = r_uid;
    assign cbus_m_data_be = r_be;
    assign cbus_m_data    = r_data;
    assign rsp_valid      = r_rsp_valid;
    assign rsp_tag        = r_rsp_tag;
    assign rsp_data       = r_rsp_data;
    assign err            = r_err;

endmodule
